// File: rtl/uart_probe_streamer.sv
// Probe-channel telemetry tap: snapshots NUM_CH channels and streams them as one
// framed, checksummed 8N1 UART packet (periodic, on-change or triggered).
module uart_probe_streamer #(
    parameter int         CLK_HZ     = 50000000,
    parameter int         BAUD       = 115200,
    parameter int         NUM_CH     = 8,
    parameter int         CH_W       = 8,
    parameter int         PERIOD_CYC = 5000000,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH*CH_W-1:0] ch_data,
    input  logic [1:0]             mode,
    input  logic                   trigger,
    output logic                   uart_tx,
    output logic                   tx_busy,
    output logic [7:0]             seq
);
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int BPC    = (CH_W + 7) / 8;
    localparam int NBYTES = NUM_CH * BPC + 3;
    localparam int DW     = NUM_CH * CH_W;
    localparam int PW     = NUM_CH * BPC * 8;
    localparam int DIVW   = $clog2(DIV);
    localparam int IDXW   = $clog2(NBYTES);
    localparam int TW     = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_NEXT} state_t;

    state_t          state_q, state_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      chk_q, chk_d;
    logic [7:0]      seq_q, seq_d;
    logic            busy_q, busy_d;
    logic            pending_q, pending_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [DW-1:0]   snap_q, snap_d;
    logic [DW-1:0]   last_q, last_d;

    logic [PW-1:0]   padded;
    logic [7:0]      cur_byte;
    logic            bit_done, stop_done, last_byte, tick, req, go;

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin : request
        tick      = (timer_q == TW'(PERIOD_CYC - 1));
        timer_d   = tick ? '0 : timer_q + 1'b1;
        bit_done  = (div_q == DIVW'(DIV - 1));
        stop_done = (div_q == DIVW'(DIV - 2));
        last_byte = (idx_q == IDXW'(NBYTES - 1));
        req = 1'b0;
        if (mode != 2'd3 && trigger)                                   req = 1'b1;
        if (mode == 2'd0 && tick)                                      req = 1'b1;
        if (mode == 2'd1 && state_q == S_IDLE && ch_data != last_q)    req = 1'b1;
        go = req || (pending_q && mode != 2'd3);
    end

    always_comb begin : byte_mux
        padded = '0;
        for (int k = 0; k < NUM_CH; k++)
            padded[k*BPC*8 +: CH_W] = snap_q[k*CH_W +: CH_W];
        cur_byte = chk_q;
        if (idx_q == '0)
            cur_byte = HEADER;
        else if (idx_q == IDXW'(1))
            cur_byte = seq_q;
        else
            for (int j = 0; j < NBYTES - 3; j++)
                if (idx_q == IDXW'(j + 2)) cur_byte = padded[j*8 +: 8];
    end

    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_LOAD;
            S_LOAD:  state_d = S_START;
            S_START: if (bit_done) state_d = S_DATA;
            S_DATA:  if (bit_done && bit_q == 3'd7) state_d = S_STOP;
            // Stop bit spends its final cycle in NEXT so bytes stay back to back.
            S_STOP:  if (stop_done) state_d = S_NEXT;
            S_NEXT:  state_d = last_byte ? S_IDLE : S_START;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : datapath
        div_d     = '0;
        bit_d     = bit_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        chk_d     = chk_q;
        seq_d     = seq_q;
        busy_d    = busy_q;
        snap_d    = snap_q;
        last_d    = last_q;
        pending_d = (pending_q && state_q != S_LOAD) || req;
        if (mode == 2'd3) pending_d = 1'b0;
        case (state_q)
            S_LOAD: begin
                snap_d = ch_data;
                last_d = ch_data;
                seq_d  = seq_q + 8'd1;
                idx_d  = '0;
                chk_d  = '0;
                busy_d = 1'b1;
            end
            S_START: begin
                if (bit_done) begin
                    shreg_d = cur_byte;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_STOP: if (!stop_done) div_d = div_q + 1'b1;
            S_NEXT: begin
                if (idx_q != '0) chk_d = chk_q + cur_byte;
                idx_d = idx_q + 1'b1;
                if (last_byte) busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin : fsm_out
        uart_tx = 1'b1;
        if (state_q == S_START)     uart_tx = 1'b0;
        else if (state_q == S_DATA) uart_tx = shreg_q[0];
    end

    assign tx_busy = busy_q;
    assign seq     = seq_q;

    // NOTE: state updates use <= so every flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            chk_q     <= '0;
            seq_q     <= 8'hFF;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
            timer_q   <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            chk_q     <= chk_d;
            seq_q     <= seq_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            last_q    <= last_d;
        end
    end

    // NOTE: the payload snapshot is always reloaded in LOAD before it is read, so it carries no reset.
    always_ff @(posedge clk) snap_q <= snap_d;

endmodule
